// File: rtl/cr_sa_snap_ctrl_pkg.sv
// Shared types and constants for the statistics-aggregator snapshot controller.
package cr_sa_snap_ctrlPKG;

    localparam int SA_CTR_WIDTH   = 50;
    localparam int SA_NUM_CTR     = 64;
    localparam int SA_EPOCH_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        SNAP,
        SETTLE,
        DUMP,
        CLEAR
    } sa_snap_state_e;

endpackage

// File: rtl/cr_sa_snap_timer.sv
// Free-running periodic snap timer; emits a one-cycle hit every cfg_period_i cycles.
// Only instantiated when CR_SA_SNAP_CTRL_PERIODIC_EN is defined.
module cr_sa_snap_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] cfg_period_i,
    output logic        hit_o
);

    logic [31:0] count_q, count_d;

    // A period lowered below the current count is only caught after the 32-bit wrap.
    always_comb begin
        hit_o   = (cfg_period_i != 32'd0) && (count_q == cfg_period_i - 32'd1);
        count_d = count_q + 32'd1;
        if (cfg_period_i == 32'd0 || hit_o) begin
            count_d = 32'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 32'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/cr_sa_snap_ctrl.sv
// Snapshot scheduler / readout sequencer for the 64-counter statistics aggregator.
// Define CR_SA_SNAP_CTRL_PERIODIC_EN to add the cfg_period-driven periodic snap timer.
//   state  | meaning
//   IDLE   | waiting for a snap request or pending clear
//   SNAP   | regs_sa_snap strobe high, epoch advanced
//   SETTLE | waiting SNAP_LAT cycles for aggregator latency
//   DUMP   | streaming snapshot counters over valid/ready
//   CLEAR  | regs_sa_clear_live strobe high
module cr_sa_snap_ctrl
    import cr_sa_snap_ctrlPKG::*;
#(
    parameter int SNAP_LAT = 4,
    parameter int NUM_CTR  = SA_NUM_CTR
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [31:0]               cfg_period,
    input  logic                      sw_snap_req,
    input  logic                      sw_clear_req,
    input  logic [SA_CTR_WIDTH-1:0]   sa_snapshot [0:NUM_CTR-1],
    output logic                      regs_sa_snap,
    output logic                      regs_sa_clear_live,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [5:0]                rd_idx,
    output logic [SA_CTR_WIDTH-1:0]   rd_data,
    output logic [SA_EPOCH_WIDTH-1:0] rd_epoch,
    output logic                      rd_last,
    output logic                      busy,
    output logic [15:0]               overrun_cnt
);

    localparam logic [5:0]  LAST_IDX   = 6'(NUM_CTR - 1);
    localparam logic [15:0] SETTLE_LD  = 16'(SNAP_LAT - 1);

    sa_snap_state_e              state_q, state_d;
    logic [5:0]                  idx_q, idx_d;
    logic [15:0]                 settle_q, settle_d;
    logic [SA_EPOCH_WIDTH-1:0]   epoch_q, epoch_d;
    logic                        pend_clr_q, pend_clr_d;
    logic [15:0]                 ovr_q, ovr_d;
    logic                        snap_q, clr_q;
    logic                        timer_hit;
    logic                        snap_req;

`ifdef CR_SA_SNAP_CTRL_PERIODIC_EN
    cr_sa_snap_timer u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_period_i (cfg_period),
        .hit_o        (timer_hit)
    );
`else
    logic unused_cfg_period;
    assign unused_cfg_period = ^cfg_period;
    assign timer_hit         = 1'b0;
`endif

    assign snap_req = sw_snap_req | timer_hit;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        settle_d   = settle_q;
        epoch_d    = epoch_q;
        pend_clr_d = pend_clr_q;
        ovr_d      = ovr_q;

        // Anything arriving outside IDLE is either dropped (snap) or deferred (clear).
        if (state_q != IDLE) begin
            if (snap_req && ovr_q != 16'hFFFF) begin
                ovr_d = ovr_q + 16'd1;
            end
            if (sw_clear_req) begin
                pend_clr_d = 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (snap_req) begin
                    state_d = SNAP;
                    epoch_d = epoch_q + 1'b1;
                    if (sw_clear_req) begin
                        pend_clr_d = 1'b1;
                    end
                end else if (pend_clr_q || sw_clear_req) begin
                    state_d    = CLEAR;
                    pend_clr_d = 1'b0;
                end
            end
            SNAP: begin
                state_d  = SETTLE;
                settle_d = SETTLE_LD;
            end
            SETTLE: begin
                if (settle_q == 16'd0) begin
                    state_d = DUMP;
                    idx_d   = 6'd0;
                end else begin
                    settle_d = settle_q - 16'd1;
                end
            end
            DUMP: begin
                if (rd_ready) begin
                    idx_d = idx_q + 6'd1;
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                    end
                end
            end
            CLEAR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= 6'd0;
            settle_q   <= 16'd0;
            epoch_q    <= '0;
            pend_clr_q <= 1'b0;
            ovr_q      <= 16'd0;
            snap_q     <= 1'b0;
            clr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            settle_q   <= settle_d;
            epoch_q    <= epoch_d;
            pend_clr_q <= pend_clr_d;
            ovr_q      <= ovr_d;
            snap_q     <= (state_d == SNAP);
            clr_q      <= (state_d == CLEAR);
        end
    end

    assign regs_sa_snap       = snap_q;
    assign regs_sa_clear_live = clr_q;
    assign rd_valid           = (state_q == DUMP);
    assign rd_idx             = idx_q;
    assign rd_data            = rd_valid ? sa_snapshot[idx_q] : '0;
    assign rd_last            = rd_valid && (idx_q == LAST_IDX);
    assign rd_epoch           = epoch_q;
    assign busy               = (state_q != IDLE);
    assign overrun_cnt        = ovr_q;

endmodule
